// File: rtl/axis_adc_decimator.sv
// -----------------------------------------------------------------------------
// axis_adc_decimator
//
// Boxcar decimator for the dual-channel ADC stream. Each input word carries
// two signed samples: channel A in the low half, channel B in the high half.
// Both channels are summed over a window of R samples, and one
// {sumB, sumA} word is emitted per window on an AXI-Stream master port.
// The upstream ADC source cannot be stalled. A result that arrives while an
// undelivered word is still held is therefore dropped, and the drop is
// counted.
//
// Ports:
//   aclk           system clock, rising edge
//   aresetn        asynchronous active-low reset
//   cfg_enable     run enable; low clears the window logic and the status
//   cfg_rate       window length R in samples (0 behaves as 1), latched per window
//   s_axis_tvalid  input sample valid
//   s_axis_tdata   {chB, chA}, two's complement
//   s_axis_tready  always 1
//   m_axis_tvalid  result valid
//   m_axis_tready  downstream accept
//   m_axis_tdata   {sumB, sumA}, two's complement, ACC_WIDTH bits each
//   sts_overrun    sticky flag: at least one result was dropped
//   sts_drop_cnt   dropped-result count, saturating at all ones
//
// ACC_WIDTH must be at least AXIS_TDATA_WIDTH/2 + CNTR_WIDTH. This keeps a
// full window of extreme samples from wrapping the sums.
// -----------------------------------------------------------------------------
module axis_adc_decimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16,
  parameter int ACC_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enable,
  input  logic [CNTR_WIDTH-1:0]       cfg_rate,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                        s_axis_tready,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [2*ACC_WIDTH-1:0]      m_axis_tdata,
  output logic                        sts_overrun,
  output logic [15:0]                 sts_drop_cnt
);

  localparam int HALF = AXIS_TDATA_WIDTH / 2;
  localparam int NCH  = 2;

  // ---------------------------------------------------------------------------
  // Window control
  // ---------------------------------------------------------------------------
  logic                  accept;
  logic                  window_last;
  logic [CNTR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNTR_WIDTH-1:0] rate_reg, rate_next;
  logic [CNTR_WIDTH-1:0] rate_eff;

  // The source never waits, so ready is constant.
  assign s_axis_tready = 1'b1;
  assign accept        = s_axis_tvalid && cfg_enable;

  // On the first sample of a window the rate is being latched in this same
  // cycle. Use cfg_rate directly so a one-sample window closes at once.
  // Later samples use the latched copy, so a mid-window rate change waits
  // until the next window.
  assign rate_eff = (cnt_reg == '0) ? cfg_rate : rate_reg;

  // Rates 0 and 1 both close the window on every sample.
  assign window_last = accept &&
                       ((rate_eff <= CNTR_WIDTH'(1)) ||
                        (cnt_reg == rate_eff - CNTR_WIDTH'(1)));

  always_comb begin
    cnt_next  = cnt_reg;
    rate_next = rate_reg;
    if (!cfg_enable) begin
      cnt_next  = '0;
      rate_next = '0;
    end else if (accept) begin
      if (cnt_reg == '0) begin
        rate_next = cfg_rate;
      end
      if (window_last) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CNTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_reg  <= '0;
      rate_reg <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      rate_reg <= rate_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel accumulators
  // ---------------------------------------------------------------------------
  // result holds the closing sums: the accumulator plus the current sample.
  // The output register can then capture a window on the same edge that
  // accepts its last sample, and the next window starts from zero with no
  // sample lost between windows.
  logic [NCH*ACC_WIDTH-1:0] result;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [HALF-1:0]      sample;
      logic [ACC_WIDTH-1:0] sample_ext;
      logic [ACC_WIDTH-1:0] sum;
      logic [ACC_WIDTH-1:0] acc_reg, acc_next;

      assign sample     = s_axis_tdata[gi*HALF +: HALF];
      assign sample_ext = {{(ACC_WIDTH-HALF){sample[HALF-1]}}, sample};
      // Two's-complement addition is sign-agnostic once both operands are
      // extended to the full width.
      assign sum        = acc_reg + sample_ext;

      always_comb begin
        acc_next = acc_reg;
        if (!cfg_enable) begin
          acc_next = '0;
        end else if (accept) begin
          acc_next = window_last ? '0 : sum;
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_next;
        end
      end

      assign result[gi*ACC_WIDTH +: ACC_WIDTH] = sum;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t             state_reg, state_next;
  logic [2*ACC_WIDTH-1:0] data_reg, data_next;
  logic                   overrun_reg, overrun_next;
  logic [15:0]            drop_reg, drop_next;
  logic                   drop_event;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    drop_event = 1'b0;

    case (state_reg)
      OUT_EMPTY: begin
        if (window_last) begin
          data_next  = result;
          state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (window_last) begin
          // A new result arriving while the held word is accepted simply
          // replaces it. Otherwise the held word must stay stable and the
          // new result is lost.
          if (m_axis_tready) begin
            data_next = result;
          end else begin
            drop_event = 1'b1;
          end
        end else if (m_axis_tready) begin
          state_next = OUT_EMPTY;
        end
      end
      default: begin
        state_next = OUT_EMPTY;
      end
    endcase
  end

  // Disabling clears the status. A pending output word still waits for
  // its consumer.
  always_comb begin
    overrun_next = overrun_reg;
    drop_next    = drop_reg;
    if (!cfg_enable) begin
      overrun_next = 1'b0;
      drop_next    = '0;
    end else if (drop_event) begin
      overrun_next = 1'b1;
      if (drop_reg != 16'hFFFF) begin
        drop_next = drop_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= OUT_EMPTY;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
      drop_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      overrun_reg <= overrun_next;
      drop_reg    <= drop_next;
    end
  end

  assign m_axis_tvalid = (state_reg == OUT_FULL);
  assign m_axis_tdata  = data_reg;
  assign sts_overrun   = overrun_reg;
  assign sts_drop_cnt  = drop_reg;

endmodule

// File: doc/axis_adc_decimator.md
Name: axis_adc_decimator

Overview:
- Downstream stage of the Red Pitaya ADC stream source.
- Consumes the 32-bit dual-channel ADC word: channel A in the low 16 bits, channel B in the high 16 bits, both sign-extended two's complement.
- Sums each channel over a programmable window of R samples (boxcar decimation by R).
- Emits one 64-bit AXI-Stream word per window toward the DMA/FIFO path.
- The upstream source cannot stall, so results that cannot be delivered are dropped and counted.

Parameters:
- AXIS_TDATA_WIDTH, 32: input word width; two channels of AXIS_TDATA_WIDTH/2 bits each.
- CNTR_WIDTH, 16: width of the decimation-rate register and window counter.
- ACC_WIDTH, 32: per-channel accumulator and output width. Must be at least AXIS_TDATA_WIDTH/2 + CNTR_WIDTH.

Ports:
- aclk  in  1  system clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- cfg_enable  in  1  run enable; low holds the window logic cleared.
- cfg_rate  in  CNTR_WIDTH  window length R in samples; 0 is treated as 1.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  {chB[15:0], chA[15:0]}, signed.
- s_axis_tready  out  1  tied to 1; the block never backpressures.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tdata  out  2*ACC_WIDTH  {sumB, sumA}, signed.
- sts_overrun  out  1  sticky: at least one result dropped.
- sts_drop_cnt  out  16  count of dropped results, saturating at 0xFFFF.

Behaviour:
- Reset (aresetn low, asynchronous):
  - accumulators, window counter, latched rate, m_axis_tdata, m_axis_tvalid, sts_overrun and sts_drop_cnt all go to 0.
  - Latched rate reloads from cfg_rate on the first accepted sample after reset.
- A sample is accepted when s_axis_tvalid && cfg_enable.
- Each accepted sample:
  - sign-extend each 16-bit half to ACC_WIDTH;
  - add to accA/accB;
  - increment the counter.
- Window rate latching:
  - rate_l is latched from cfg_rate when the counter is 0 and a sample is accepted.
  - A cfg_rate change mid-window is ignored until the next window.
- Window end: on the accepted sample where counter == rate_l-1 (or rate_l <= 1):
  - final sum = acc + current sample, computed in the same cycle;
  - accumulators reset to 0 and the counter returns to 0 on the same edge (no sample lost between windows).
- Latency: the result appears on m_axis_tdata with m_axis_tvalid=1 on the clock edge after the last sample of the window, i.e. one cycle.
- Output register handshake, evaluated when a new result arrives:
  - tvalid=0: load the result, tvalid <= 1.
  - tvalid=1 && tready=1 (simultaneous accept and new result): load the new result, tvalid stays 1, nothing dropped.
  - tvalid=1 && tready=0: the new result is discarded, the held word is unchanged, sts_overrun <= 1, sts_drop_cnt increments (saturating).
  - No new result, tvalid && tready: tvalid <= 0.
  - m_axis_tdata is stable while tvalid && !tready.
- cfg_enable low:
  - accumulators, counter and rate_l clear synchronously;
  - sts_overrun and sts_drop_cnt clear;
  - a pending output word is held until accepted.
- Re-raising cfg_enable starts a fresh window on the next accepted sample.
- Arithmetic: full-precision signed sums with no saturation. Worst case -32768*65535 = -2147450880 fits in 32 bits.
- s_axis_tvalid low stalls accumulation; the counter and accumulators hold.
- Reset asserted mid-window: the partial window is discarded and no output is generated for it.

Test Plan:
- cfg_rate=4, four samples chA=+1, chB=-2, tready=1 -> one cycle after the 4th sample, m_axis_tdata=0xFFFFFFF8_00000004 with tvalid for exactly one cycle; next window starts cleanly.
- cfg_rate=0, then 1, samples 0x0005FFFD -> every sample yields an output word 0x00000005_FFFFFFFD, one cycle later, tvalid continuous.
- cfg_rate=65535, all samples 0x80008000 -> output sumA=sumB=0x80008000 (-2147450880), no overflow.
- cfg_rate=2, tready=0 for 3 windows -> first result held unchanged, sts_overrun=1, sts_drop_cnt=2. Then tready=1 -> held word taken. Also drive tready=1 on the same cycle as a new result -> no drop.
- cfg_rate changed 4->8 after 2 samples of a window -> the current window still closes after 4 samples; the following window uses 8.
- aresetn pulsed low after 3 of 4 samples (rate 4) -> all outputs 0 immediately; the next output needs 4 fresh samples. cfg_enable low mid-window behaves the same, except a pending output word is retained.
